param_reg_file: RTL and testbench

Parametrised general-purpose plus scratch register file for the datapath: N_GP architectural registers and N_SCR scratch registers of DATA_W bits, each updated by a per-register function unit driven from a narrow IN_W-bit input bus. Two combinational read ports feed the ALU/address path. It adds a multi-beat burst load, which assembles a full DATA_W word from successive IN_W chunks and commits it atomically. It also gives a clean, non-overlapping function encoding with sign-extended load and shift-in.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_burst_assembler.sv | 90 +++++++++
 rtl/param_reg_file.sv | 96 +++++++++
 tb/tb_param_reg_file.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file:
// function-select codes and the burst assembler state encoding.
package rf_pkg;

    localparam logic [2:0] FS_DEC    = 3'b000;
    localparam logic [2:0] FS_INC    = 3'b001;
    localparam logic [2:0] FS_LOAD   = 3'b010;
    localparam logic [2:0] FS_CLR    = 3'b011;
    localparam logic [2:0] FS_SHL    = 3'b100;
    localparam logic [2:0] FS_LOADSX = 3'b101;
    localparam logic [2:0] FS_BURST  = 3'b110;
    localparam logic [2:0] FS_HOLD   = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } burst_state_t;

endpackage

// File: rtl/rf_burst_assembler.sv
// Collects DATA_W/IN_W little-endian beats into one word and flags a single-cycle
// commit, together with the latched target mask, on the edge that takes the last beat.
module rf_burst_assembler
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IN_W   = 8,
    parameter int N_TOT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        fun_sel,
    input  logic [N_TOT-1:0]  sel,
    input  logic [IN_W-1:0]   data,
    input  logic              in_valid,
    output logic              busy,
    output logic              commit,
    output logic [DATA_W-1:0] word,
    output logic [N_TOT-1:0]  masks
);

    localparam int BEATS = DATA_W / IN_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    burst_state_t      state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DATA_W-1:0] asm_q, asm_nx;
    logic [N_TOT-1:0]  mask_q, mask_nx;
    logic              start;

    assign start = (fun_sel == FS_BURST) && (|sel);
    assign busy  = (state == ST_COLLECT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            asm_q  <= '0;
            mask_q <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            asm_q  <= asm_nx;
            mask_q <= mask_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        asm_nx   = asm_q;
        mask_nx  = mask_q;
        commit   = 1'b0;
        word     = asm_q;
        masks    = mask_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (BEATS == 1) begin
                        // Single-beat word: commit straight from the start edge.
                        commit = 1'b1;
                        word   = DATA_W'(data);
                        masks  = sel;
                    end else begin
                        state_nx = ST_COLLECT;
                        mask_nx  = sel;
                        asm_nx   = DATA_W'(data);
                        cnt_nx   = CNT_W'(1);
                    end
                end
            end
            ST_COLLECT: begin
                if (in_valid) begin
                    asm_nx[int'(cnt)*IN_W +: IN_W] = data;
                    if (cnt == CNT_W'(BEATS - 1)) begin
                        commit   = 1'b1;
                        word     = asm_nx;
                        masks    = mask_q;
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/param_reg_file.sv
// General-purpose plus scratch register file with per-register function apply,
// a burst word loader and two combinational read ports (out-of-range reads return 0).
module param_reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IN_W   = 8,
    parameter int N_GP   = 4,
    parameter int N_SCR  = 4,
    localparam int N_TOT = N_GP + N_SCR,
    localparam int SEL_W = $clog2(N_TOT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        FunSel,
    input  logic [N_GP-1:0]   RegSel,
    input  logic [N_SCR-1:0]  ScrSel,
    input  logic [IN_W-1:0]   I,
    input  logic              in_valid,
    input  logic [SEL_W-1:0]  OutASel,
    input  logic [SEL_W-1:0]  OutBSel,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB,
    output logic              busy
);

    logic [DATA_W-1:0] regs [N_TOT];
    logic [DATA_W-1:0] rd_tab [2**SEL_W];
    logic [N_TOT-1:0]  sel;
    logic              commit;
    logic [DATA_W-1:0] cmt_word;
    logic [N_TOT-1:0]  cmt_mask;

    assign sel = {ScrSel, RegSel};

    function automatic logic [DATA_W-1:0] apply(input logic [2:0]        fs,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic [IN_W-1:0]   d);
        logic [DATA_W-1:0] res;
        res = r;
        case (fs)
            FS_DEC:    res = r - DATA_W'(1);
            FS_INC:    res = r + DATA_W'(1);
            FS_LOAD:   res = DATA_W'(d);
            FS_CLR:    res = '0;
            FS_SHL:    res = (r << IN_W) | DATA_W'(d);
            FS_LOADSX: res = DATA_W'($signed(d));
            default:   res = r;
        endcase
        return res;
    endfunction

    rf_burst_assembler #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W),
        .N_TOT  (N_TOT)
    ) u_burst (
        .clk      (clk),
        .rst      (rst),
        .fun_sel  (FunSel),
        .sel      (sel),
        .data     (I),
        .in_valid (in_valid),
        .busy     (busy),
        .commit   (commit),
        .word     (cmt_word),
        .masks    (cmt_mask)
    );

    // While a burst is collecting, only its own commit may touch the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_TOT; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < N_TOT; k++) begin
                if (commit) begin
                    if (cmt_mask[k]) regs[k] <= cmt_word;
                end else if (!busy && sel[k]) begin
                    regs[k] <= apply(FunSel, regs[k], I);
                end
            end
        end
    end

    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_rd
        if (k < N_TOT) begin : g_live
            assign rd_tab[k] = regs[k];
        end else begin : g_pad
            assign rd_tab[k] = '0;
        end
    end

    assign OutA = rd_tab[OutASel];
    assign OutB = rd_tab[OutBSel];

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file at default parameters (32-bit words, 8-bit beats,
// 4 GP + 4 scratch registers); every expected value is hand-computed.
module tb_param_reg_file;
    import rf_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [7:0]  I;
    logic        in_valid;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [31:0] OutA;
    logic [31:0] OutB;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    param_reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .FunSel   (FunSel),
        .RegSel   (RegSel),
        .ScrSel   (ScrSel),
        .I        (I),
        .in_valid (in_valid),
        .OutASel  (OutASel),
        .OutBSel  (OutBSel),
        .OutA     (OutA),
        .OutB     (OutB),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one op for one edge, then return to HOLD; leaves time at posedge+1.
    task automatic op(input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss,
                      input logic [7:0] d);
        FunSel = fs; RegSel = rs; ScrSel = ss; I = d;
        @(posedge clk); #1;
        FunSel = FS_HOLD; RegSel = 4'b0; ScrSel = 4'b0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] v);
        OutASel = idx;
        #1;
        v = OutA;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        for (int k = 0; k < 8; k++) begin
            rd(3'(k), v);
            checks++;
            if (v !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=%h", k, v, 32'h0);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] v;
        op(FS_LOAD, 4'b0001, 4'b0000, 8'h5A);
        rd(3'd0, v);
        checks++;
        if (v !== 32'h0000005A) begin
            failures++;
            $display("FAIL midop_load got=%h exp=%h", v, 32'h5A);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (OutA !== 32'h0) begin
            failures++;
            $display("FAIL midop_reset_r0 got=%h exp=%h", OutA, 32'h0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset_busy got=%b exp=0", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        logic [31:0] v;
        op(FS_CLR, 4'b0010, 4'b0000, 8'h00);
        op(FS_DEC, 4'b0010, 4'b0000, 8'h00);
        rd(3'd1, v);
        checks++;
        if (v !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL dec_wrap got=%h exp=%h", v, 32'hFFFFFFFF);
        end
        rd(3'd0, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL dec_unselected got=%h exp=%h", v, 32'h0);
        end
        op(FS_INC, 4'b0010, 4'b0000, 8'h00);
        rd(3'd1, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL inc_wrap got=%h exp=%h", v, 32'h0);
        end
        op(FS_INC, 4'b0010, 4'b0000, 8'h00);
        rd(3'd1, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL inc_plain got=%h exp=%h", v, 32'h1);
        end
    endtask

    task automatic test_loadsx_shl;
        logic [31:0] v;
        op(FS_LOADSX, 4'b0000, 4'b0001, 8'h80);
        rd(3'd4, v);
        checks++;
        if (v !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL loadsx_neg got=%h exp=%h", v, 32'hFFFFFF80);
        end
        op(FS_SHL, 4'b0000, 4'b0001, 8'h12);
        OutBSel = 3'd4;
        #1;
        checks++;
        if (OutB !== 32'hFFFF8012) begin
            failures++;
            $display("FAIL shl_portb got=%h exp=%h", OutB, 32'hFFFF8012);
        end
        op(FS_LOADSX, 4'b0000, 4'b0010, 8'h7F);
        rd(3'd5, v);
        checks++;
        if (v !== 32'h0000007F) begin
            failures++;
            $display("FAIL loadsx_pos got=%h exp=%h", v, 32'h7F);
        end
    endtask

    task automatic test_multi_select;
        logic [31:0] v;
        logic [31:0] exp_tab [8];
        op(FS_LOAD, 4'b0001, 4'b0000, 8'h77);
        op(FS_LOAD, 4'b0000, 4'b0010, 8'h55);
        op(FS_LOAD, 4'b1010, 4'b0001, 8'h3C);
        exp_tab = '{32'h77, 32'h3C, 32'h0, 32'h3C, 32'h3C, 32'h55, 32'h0, 32'h0};
        for (int k = 0; k < 8; k++) begin
            rd(3'(k), v);
            checks++;
            if (v !== exp_tab[k]) begin
                failures++;
                $display("FAIL multi_reg%0d got=%h exp=%h", k, v, exp_tab[k]);
            end
        end
    endtask

    task automatic test_burst_stall;
        logic [31:0] v;
        int busy_cycles;
        busy_cycles = 0;
        OutASel = 3'd0;
        OutBSel = 3'd1;
        FunSel = FS_BURST; RegSel = 4'b0001; ScrSel = 4'b0000; I = 8'h11; in_valid = 1'b0;
        @(posedge clk); #1;
        if (busy) busy_cycles++;
        // Conflicting op held for the whole burst; must not take effect.
        FunSel = FS_CLR; RegSel = 4'b1111;
        in_valid = 1'b1; I = 8'h22;
        @(posedge clk); #1;
        if (busy) busy_cycles++;
        checks++;
        if (OutA !== 32'h77) begin
            failures++;
            $display("FAIL burst_no_early_write got=%h exp=%h", OutA, 32'h77);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (busy) busy_cycles++;
        in_valid = 1'b1; I = 8'h33;
        @(posedge clk); #1;
        if (busy) busy_cycles++;
        I = 8'h44;
        @(posedge clk); #1;
        if (busy) busy_cycles++;
        FunSel = FS_HOLD; RegSel = 4'b0; in_valid = 1'b0;
        checks++;
        if (OutA !== 32'h44332211) begin
            failures++;
            $display("FAIL burst_commit got=%h exp=%h", OutA, 32'h44332211);
        end
        checks++;
        if (OutB !== 32'h3C) begin
            failures++;
            $display("FAIL burst_clr_ignored got=%h exp=%h", OutB, 32'h3C);
        end
        checks++;
        if (busy_cycles !== 4) begin
            failures++;
            $display("FAIL burst_busy_cycles got=%0d exp=4", busy_cycles);
        end
        rd(3'd3, v);
        checks++;
        if (v !== 32'h3C) begin
            failures++;
            $display("FAIL burst_clr_ignored_r3 got=%h exp=%h", v, 32'h3C);
        end
    endtask

    task automatic test_burst_abort;
        logic [7:0] beats [4];
        beats = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        OutASel = 3'd0;
        FunSel = FS_BURST; RegSel = 4'b0001; I = 8'hEE; in_valid = 1'b0;
        @(posedge clk); #1;
        FunSel = FS_HOLD; RegSel = 4'b0;
        in_valid = 1'b1; I = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || OutA !== 32'h0) begin
            failures++;
            $display("FAIL abort_reset got busy=%b r0=%h exp busy=0 r0=%h", busy, OutA, 32'h0);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        FunSel = FS_BURST; RegSel = 4'b0001; I = beats[0];
        @(posedge clk); #1;
        FunSel = FS_HOLD; RegSel = 4'b0; in_valid = 1'b1;
        for (int b = 1; b < 4; b++) begin
            I = beats[b];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (OutA !== 32'hD4C3B2A1) begin
            failures++;
            $display("FAIL abort_reburst got=%h exp=%h", OutA, 32'hD4C3B2A1);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_reburst_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        // INC issued in the very cycle busy has dropped.
        op(FS_INC, 4'b0001, 4'b0000, 8'h00);
        rd(3'd0, v);
        checks++;
        if (v !== 32'hD4C3B2A2) begin
            failures++;
            $display("FAIL b2b_inc got=%h exp=%h", v, 32'hD4C3B2A2);
        end
        FunSel = FS_BURST; RegSel = 4'b0100; ScrSel = 4'b1000; I = 8'h01;
        @(posedge clk); #1;
        FunSel = FS_HOLD; RegSel = 4'b0; ScrSel = 4'b0; in_valid = 1'b1;
        I = 8'h02; @(posedge clk); #1;
        I = 8'h03; @(posedge clk); #1;
        I = 8'h04; @(posedge clk); #1;
        in_valid = 1'b0;
        OutASel = 3'd2;
        OutBSel = 3'd7;
        #1;
        checks++;
        if (OutA !== 32'h04030201 || OutB !== 32'h04030201) begin
            failures++;
            $display("FAIL multi_burst got r2=%h r7=%h exp=%h", OutA, OutB, 32'h04030201);
        end
        rd(3'd0, v);
        checks++;
        if (v !== 32'hD4C3B2A2) begin
            failures++;
            $display("FAIL multi_burst_untouched got=%h exp=%h", v, 32'hD4C3B2A2);
        end
        // BURST with empty masks must not start collection.
        op(FS_BURST, 4'b0000, 4'b0000, 8'h99);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_burst_busy got=%b exp=0", busy);
        end
    endtask

    initial begin
        rst = 1'b0;
        FunSel = FS_HOLD; RegSel = 4'b0; ScrSel = 4'b0; I = 8'h0; in_valid = 1'b0;
        OutASel = 3'd0; OutBSel = 3'd0;
        #12;
        test_reset;
        test_reset_mid_op;
        test_wrap;
        test_loadsx_shl;
        test_multi_select;
        test_burst_stall;
        test_burst_abort;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
